// File: rtl/conmutador_baterias_pkg.sv
// -----------------------------------------------------------------------------
// conmutador_baterias_pkg
// Shared definitions for the two-battery supervisor:
//   - ANCHO_CARGA    : width of the charge-level inputs
//   - ANCHO_CONTEO   : width of the switchover counter
//   - estado_t       : supervisor FSM states
//   - activa_t codes : values reported on bateria_activa
//   - max_int        : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package conmutador_baterias_pkg;

  localparam int ANCHO_CARGA  = 4;
  localparam int ANCHO_CONTEO = 8;

  typedef enum logic [2:0] {
    INICIO,
    USA_B1,
    USA_B2,
    CONMUTANDO,
    SIN_ENERGIA
  } estado_t;

  typedef logic [1:0] activa_t;

  localparam activa_t ACTIVA_NINGUNA = 2'd0;
  localparam activa_t ACTIVA_B1      = 2'd1;
  localparam activa_t ACTIVA_B2      = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conmutador_baterias_filtro_descarga.sv
// -----------------------------------------------------------------------------
// filtro_descarga
// Turns one raw 4-bit charge level into a debounced "discharged" flag.
// The flag only toggles after the opposing raw condition has been seen on
// FILTRO_CICLOS consecutive edges; any agreeing edge restarts the count.
// The flag starts at 1 so a battery must prove it is charged before use.
//
// Optional feature (macro CONMUTADOR_HISTERESIS_EN):
//   defined   : a set flag clears only when carga >= UMBRAL_BAJO + HISTERESIS
//               (5-bit sum; above 15 the flag can never clear)
//   undefined : a set flag clears when carga > UMBRAL_BAJO
//
// Ports:
//   clk      in  1  rising-edge clock
//   rst      in  1  asynchronous active-high reset
//   i_carga  in  4  unsigned charge level
//   o_baja   out 1  filtered discharged flag (reset value 1)
// -----------------------------------------------------------------------------
module filtro_descarga
  import conmutador_baterias_pkg::*;
#(
  parameter int UMBRAL_BAJO   = 2,
  parameter int FILTRO_CICLOS = 4
`ifdef CONMUTADOR_HISTERESIS_EN
  ,
  parameter int HISTERESIS    = 3
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ANCHO_CARGA-1:0] i_carga,
  output logic                   o_baja
);

  localparam int ANCHO_CNT = $clog2(FILTRO_CICLOS + 1);
  localparam logic [ANCHO_CNT-1:0]   CNT_FINAL = ANCHO_CNT'(FILTRO_CICLOS - 1);
  localparam logic [ANCHO_CARGA-1:0] UMBRAL    = ANCHO_CARGA'(UMBRAL_BAJO);

  logic                 r_baja;
  logic [ANCHO_CNT-1:0] r_cnt;
  logic                 w_cruda_baja;
  logic                 w_cruda_alta;
  logic                 w_difiere;

  assign w_cruda_baja = (i_carga <= UMBRAL);

`ifdef CONMUTADOR_HISTERESIS_EN
  localparam int ANCHO_SUMA = ANCHO_CARGA + 1;
  localparam logic [ANCHO_SUMA-1:0] UMBRAL_SUBIDA =
    ANCHO_SUMA'(UMBRAL_BAJO) + ANCHO_SUMA'(HISTERESIS);
  // Zero-extended compare: a threshold above 15 is simply unreachable.
  assign w_cruda_alta = ({1'b0, i_carga} >= UMBRAL_SUBIDA);
`else
  assign w_cruda_alta = !w_cruda_baja;
`endif

  // The condition that would move the flag away from its current value.
  assign w_difiere = r_baja ? w_cruda_alta : w_cruda_baja;

  // Counting to FILTRO_CICLOS-1 and toggling on the next differing edge
  // makes the flag change on the FILTRO_CICLOS-th consecutive edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baja <= 1'b1;
      r_cnt  <= '0;
    end else if (w_difiere) begin
      if (r_cnt == CNT_FINAL) begin
        r_baja <= !r_baja;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_baja = r_baja;

endmodule

// File: rtl/conmutador_baterias.sv
// -----------------------------------------------------------------------------
// conmutador_baterias
// Two-battery supervisor. Each charge level is debounced into a discharged
// flag; a break-before-make FSM selects which battery feeds the load, with a
// dead time of TIEMPO_MUERTO cycles where both enables are low.
//
// Optional feature: CONMUTADOR_HISTERESIS_EN enables the HISTERESIS margin
// for clearing a discharged flag (see filtro_descarga).
//
// Ports:
//   clk                    in  1  rising-edge clock
//   rst                    in  1  asynchronous active-high reset
//   carga_bateria1/2       in  4  unsigned charge levels
//   habilitar_bateria1/2   out 1  battery enables (never both high)
//   advertencia_bateria_1/2 out 1 filtered discharged flags
//   falla_total            out 1  no usable battery, nothing connected
//   bateria_activa         out 2  0 none, 1 battery 1, 2 battery 2
//   num_conmutaciones      out 8  saturating count of completed switchovers
// All outputs are registered.
// -----------------------------------------------------------------------------
module conmutador_baterias
  import conmutador_baterias_pkg::*;
#(
  parameter int UMBRAL_BAJO   = 2,
  parameter int FILTRO_CICLOS = 4,
  parameter int TIEMPO_MUERTO = 3
`ifdef CONMUTADOR_HISTERESIS_EN
  ,
  parameter int HISTERESIS    = 3
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ANCHO_CARGA-1:0]  carga_bateria1,
  input  logic [ANCHO_CARGA-1:0]  carga_bateria2,
  output logic                    habilitar_bateria1,
  output logic                    habilitar_bateria2,
  output logic                    advertencia_bateria_1,
  output logic                    advertencia_bateria_2,
  output logic                    falla_total,
  output logic [1:0]              bateria_activa,
  output logic [ANCHO_CONTEO-1:0] num_conmutaciones
);

  // One timer serves both INICIO (counts up to FILTRO_CICLOS) and the dead time.
  localparam int ANCHO_TIMER = $clog2(max_int(FILTRO_CICLOS, TIEMPO_MUERTO) + 1);
  localparam logic [ANCHO_TIMER-1:0] T_INICIO = ANCHO_TIMER'(FILTRO_CICLOS);
  localparam logic [ANCHO_TIMER-1:0] T_MUERTO = ANCHO_TIMER'(TIEMPO_MUERTO - 1);

  logic [ANCHO_CARGA-1:0] w_carga [2];
  logic [1:0]             w_baja;

  assign w_carga[0] = carga_bateria1;
  assign w_carga[1] = carga_bateria2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filtro
      filtro_descarga #(
        .UMBRAL_BAJO  (UMBRAL_BAJO),
        .FILTRO_CICLOS(FILTRO_CICLOS)
`ifdef CONMUTADOR_HISTERESIS_EN
        ,
        .HISTERESIS   (HISTERESIS)
`endif
      ) u_filtro (
        .clk    (clk),
        .rst    (rst),
        .i_carga(w_carga[gi]),
        .o_baja (w_baja[gi])
      );
    end
  endgenerate

  estado_t                 r_estado, w_estado_next;
  logic [ANCHO_TIMER-1:0]  r_timer, w_timer_next;
  activa_t                 r_objetivo, w_objetivo_next;
  logic                    w_completa;

  logic                    r_en1, r_en2, r_falla;
  activa_t                 r_activa;
  logic [ANCHO_CONTEO-1:0] r_num;
  logic                    w_en1_next, w_en2_next, w_falla_next;
  activa_t                 w_activa_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado   <= INICIO;
      r_timer    <= '0;
      r_objetivo <= ACTIVA_B1;
    end else begin
      r_estado   <= w_estado_next;
      r_timer    <= w_timer_next;
      r_objetivo <= w_objetivo_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_estado_next   = r_estado;
    w_objetivo_next = r_objetivo;
    w_completa      = 1'b0;
    unique case (r_estado)
      INICIO: begin
        if (r_timer == T_INICIO) begin
          if (!w_baja[0])      w_estado_next = USA_B1;
          else if (!w_baja[1]) w_estado_next = USA_B2;
          else                 w_estado_next = SIN_ENERGIA;
        end
      end
      USA_B1: begin
        if (w_baja[0] && w_baja[1]) begin
          w_estado_next = SIN_ENERGIA;
        end else if (w_baja[0]) begin
          w_estado_next   = CONMUTANDO;
          w_objetivo_next = ACTIVA_B2;
        end
      end
      USA_B2: begin
        if (w_baja[0] && w_baja[1]) begin
          w_estado_next = SIN_ENERGIA;
        end else if (w_baja[1]) begin
          w_estado_next   = CONMUTANDO;
          w_objetivo_next = ACTIVA_B1;
        end
      end
      CONMUTANDO: begin
        // The target is re-checked only on the last dead-time cycle, so a
        // flag that reasserted meanwhile sends us to SIN_ENERGIA.
        if (r_timer == T_MUERTO) begin
          if (r_objetivo == ACTIVA_B1 && !w_baja[0]) begin
            w_estado_next = USA_B1;
            w_completa    = 1'b1;
          end else if (r_objetivo == ACTIVA_B2 && !w_baja[1]) begin
            w_estado_next = USA_B2;
            w_completa    = 1'b1;
          end else begin
            w_estado_next = SIN_ENERGIA;
          end
        end
      end
      SIN_ENERGIA: begin
        if (!w_baja[0]) begin
          w_estado_next   = CONMUTANDO;
          w_objetivo_next = ACTIVA_B1;
        end else if (!w_baja[1]) begin
          w_estado_next   = CONMUTANDO;
          w_objetivo_next = ACTIVA_B2;
        end
      end
      default: w_estado_next = INICIO;
    endcase

    // Timer restarts on every state change and only runs where it is needed.
    if (w_estado_next != r_estado)
      w_timer_next = '0;
    else if (r_estado == INICIO || r_estado == CONMUTANDO)
      w_timer_next = r_timer + 1'b1;
    else
      w_timer_next = '0;
  end

  // Output logic: decoded from the next state so the registered outputs
  // change on the same edge as the state.
  always_comb begin
    w_en1_next    = (w_estado_next == USA_B1);
    w_en2_next    = (w_estado_next == USA_B2);
    w_falla_next  = (w_estado_next == SIN_ENERGIA);
    w_activa_next = ACTIVA_NINGUNA;
    if (w_en1_next)      w_activa_next = ACTIVA_B1;
    else if (w_en2_next) w_activa_next = ACTIVA_B2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en1    <= 1'b0;
      r_en2    <= 1'b0;
      r_falla  <= 1'b0;
      r_activa <= ACTIVA_NINGUNA;
      r_num    <= '0;
    end else begin
      r_en1    <= w_en1_next;
      r_en2    <= w_en2_next;
      r_falla  <= w_falla_next;
      r_activa <= w_activa_next;
      if (w_completa && r_num != {ANCHO_CONTEO{1'b1}})
        r_num <= r_num + 1'b1;
    end
  end

  assign habilitar_bateria1    = r_en1;
  assign habilitar_bateria2    = r_en2;
  assign advertencia_bateria_1 = w_baja[0];
  assign advertencia_bateria_2 = w_baja[1];
  assign falla_total           = r_falla;
  assign bateria_activa        = r_activa;
  assign num_conmutaciones     = r_num;

endmodule
